instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the single-cycle MIPS core: it owns the program counter, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word to the decode/control stage with a valid/ready handshake. Its `opcode` output feeds the control decoder. The control decoder's `jump`, the datapath's `branch & zero`, and the immediate/index fields come back as redirect inputs. Those inputs are consulted only on the cycle the current instruction is accepted.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  word-aligned fetch address; equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; only meaningful while `imem_req` is 1.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` holds a fetched, unconsumed instruction.
- `instr_ready`  in  1  downstream accepts `instr` this cycle.
- `instr`  out  32  held instruction register.
- `opcode`  out  6  `instr[31:26]`.
- `pc`  out  32  address of the held or in-flight instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `jump`  in  1  take jump; sampled at accept.
- `branch_taken`  in  1  branch resolved taken; sampled at accept.
- `branch_imm`  in  16  branch offset, in words.
- `jump_index`  in  26  jump target field.

## Operation
- FSM states: BOOT, FETCH, HOLD.
- Reset (async) forces the following:
  - state=BOOT, `pc`=RESET_PC, `imem_req`=0, `instr_valid`=0, `instr`=0.
  - `opcode`, `pc_plus4` follow combinationally from `instr` and `pc`.
- BOOT: on the next edge, go to FETCH and set `imem_req`=1.
- FETCH:
  - `imem_req`=1; `imem_addr`=`pc` stays stable until ack.
  - When `imem_ack`=1, capture `imem_rdata` into `instr`, set `instr_valid`=1, clear `imem_req`, go to HOLD.
- HOLD:
  - `instr_valid`=1; `instr` and `pc` stay stable.
  - When `instr_ready`=1 (accept), load the next PC, clear `instr_valid`, set `imem_req`=1, go to FETCH.
- Next PC, in priority order:
  - `jump`=1: `{pc_plus4[31:28], jump_index, 2'b00}`.
  - else `branch_taken`=1: `pc_plus4 + (sign_extend(branch_imm) << 2)`, 32-bit wrap.
  - else `pc_plus4`.
- Boundary conditions:
  - Redirect inputs are ignored outside the accept cycle.
  - `jump` and `branch_taken` both 1: jump wins.
  - `pc` = 32'hFFFF_FFFC falls through to 32'h0000_0000.
  - `imem_ack` while `imem_req`=0 is ignored; `instr` is unchanged.
  - `instr_ready` while `instr_valid`=0 is ignored.
  - Reset asserted mid-FETCH or mid-HOLD aborts immediately: `imem_req` and `instr_valid` drop asynchronously, and the pending ack or instruction is discarded.

## Timing
- Reset release, then the first edge reaches BOOT→FETCH, so `imem_req`=1 one cycle after reset release.
- Ack in cycle t gives `instr_valid`=1 in t+1 (1-cycle latency).
- Accept in cycle m gives `imem_req`=1 with the new `imem_addr` in m+1.
- Zero-wait memory (ack in the same cycle as req) with `instr_ready` held at 1 sustains one instruction every 2 cycles.
- Each memory wait cycle adds one cycle; each backpressure cycle adds one cycle.
- `imem_addr` never changes while `imem_req`=1 and `imem_ack`=0.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds outputs `perf_fetched` (32) and `perf_wait` (32), both reset to 0.
  - `perf_fetched` increments on every req&ack.
  - `perf_wait` increments on every cycle with `imem_req`=1 and `imem_ack`=0.
  - Both wrap at 2^32.
- `IFETCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset check: hold `reset`=1 with RESET_PC=32'h0000_0100 → `pc`=0x100, `imem_req`=0, `instr_valid`=0. Release → `imem_req`=1, `imem_addr`=0x100 exactly one cycle later.
- Sequential fetch: ack in the same cycle as req, `instr_ready`=1, no redirects → addresses 0x100, 0x104, 0x108 issued on alternate cycles; `instr` matches the memory words in order.
- Wait states and backpressure: ack delayed 3 cycles, then `instr_ready` low 2 cycles →
  - `imem_addr` stable across the wait.
  - `instr` and `pc` stable during backpressure.
  - With perf on: `perf_wait`=3, `perf_fetched`=1.
- Branch backward: accept at `pc`=0x100 with `branch_taken`=1, `branch_imm`=16'hFFFF → next `imem_addr`=0x100. With `branch_imm`=16'h0003 → 0x110.
- Jump priority and wrap:
  - Accept at `pc`=0x4000_0000 with `jump`=1, `branch_taken`=1, `jump_index`=26'h000_0040 → next `imem_addr`=0x4000_0100.
  - `pc`=0xFFFF_FFFC with no redirect → next `imem_addr`=0x0.
- Reset mid-fetch: assert `reset` while waiting for ack, then pulse `imem_ack` during reset → `imem_req` drops in the same cycle, `instr` stays 0, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction fetch stage: PC, imem req/ack, decode valid/ready.
// Optional IFETCH_PERF_EN adds fetch and wait-cycle counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];

  // Word offset scaled to bytes; the 32-bit add wraps naturally.
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // Redirect inputs only matter on this accept cycle.
        if (instr_ready) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d       = BOOT;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_wait_d    = perf_wait_q;
    if (imem_req_q && imem_ack) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (imem_req_q && !imem_ack) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'h0000_0000;
      perf_wait_q    <= 32'h0000_0000;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_wait_q    <= perf_wait_d;
    end
  end
`endif

endmodule
